// File: rtl/display_scheduler.sv
// display_scheduler: latches four sensor readings, converts the shown pair
// to packed BCD with a double-dabble engine and rotates two display pages.
module display_scheduler #(
    parameter int unsigned DWELL_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] ch_data0,
    input  logic [13:0] ch_data1,
    input  logic [13:0] ch_data2,
    input  logic [13:0] ch_data3,
    input  logic [3:0]  ch_valid,
    input  logic        hold,
    input  logic        next_page,
    output logic [15:0] value1,
    output logic [15:0] value2,
    output logic        page,
    output logic        busy,
    output logic        upd
);
    localparam logic [13:0] SAT_MAX    = 14'd9999;
    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CONV, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [13:0] ch_data [4];
    logic [13:0] sh_q [4];
    logic [13:0] sh_d [4];
    logic [31:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        tgt_q, tgt_d;
    logic [13:0] bin_a_q, bin_a_d;
    logic [13:0] bin_b_q, bin_b_d;
    logic [15:0] bcd_a_q, bcd_a_d;
    logic [15:0] bcd_b_q, bcd_b_d;
    logic [3:0]  step_q, step_d;
    logic [15:0] value1_q, value1_d;
    logic [15:0] value2_q, value2_d;
    logic        page_q, page_d;
    logic        busy_q, busy_d;
    logic        upd_q, upd_d;
    logic        trig;

    assign ch_data[0] = ch_data0;
    assign ch_data[1] = ch_data1;
    assign ch_data[2] = ch_data2;
    assign ch_data[3] = ch_data3;

    // One double-dabble step: correct nibbles >= 5, then shift {bcd, bin}.
    function automatic logic [29:0] dabble_step(input logic [15:0] bcd,
                                                input logic [13:0] bin);
        logic [15:0] adj;
        adj = '0;
        for (int n = 0; n < 4; n++) begin
            if (bcd[4*n +: 4] >= 4'd5) begin
                adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
            end else begin
                adj[4*n +: 4] = bcd[4*n +: 4];
            end
        end
        return {adj, bin} << 1;
    endfunction

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        tgt_d    = tgt_q;
        bin_a_d  = bin_a_q;
        bin_b_d  = bin_b_q;
        bcd_a_d  = bcd_a_q;
        bcd_b_d  = bcd_b_q;
        step_d   = step_q;
        value1_d = value1_q;
        value2_d = value2_q;
        page_d   = page_q;
        busy_d   = busy_q;
        upd_d    = 1'b0;
        trig     = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (ch_valid[i]) begin
                sh_d[i] = (ch_data[i] > SAT_MAX) ? SAT_MAX : ch_data[i];
            end
        end

        if (state_q != IDLE && next_page) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                trig = next_page | pend_q | (cnt_q == DWELL_LAST);
                if (trig) begin
                    tgt_d   = page_q ^ (next_page | pend_q | ~hold);
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            LOAD: begin
                bin_a_d = sh_q[{tgt_q, 1'b0}];
                bin_b_d = sh_q[{tgt_q, 1'b1}];
                bcd_a_d = '0;
                bcd_b_d = '0;
                step_d  = '0;
                state_d = CONV;
            end
            CONV: begin
                {bcd_a_d, bin_a_d} = dabble_step(bcd_a_q, bin_a_q);
                {bcd_b_d, bin_b_d} = dabble_step(bcd_b_q, bin_b_q);
                step_d = step_q + 4'd1;
                if (step_q == 4'd13) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                value1_d = bcd_a_q;
                value2_d = bcd_b_q;
                page_d   = tgt_q;
                upd_d    = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_q     <= '{default: '0};
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            tgt_q    <= 1'b0;
            bin_a_q  <= '0;
            bin_b_q  <= '0;
            bcd_a_q  <= '0;
            bcd_b_q  <= '0;
            step_q   <= '0;
            value1_q <= '0;
            value2_q <= '0;
            page_q   <= 1'b0;
            busy_q   <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            tgt_q    <= tgt_d;
            bin_a_q  <= bin_a_d;
            bin_b_q  <= bin_b_d;
            bcd_a_q  <= bcd_a_d;
            bcd_b_q  <= bcd_b_d;
            step_q   <= step_d;
            value1_q <= value1_d;
            value2_q <= value2_d;
            page_q   <= page_d;
            busy_q   <= busy_d;
            upd_q    <= upd_d;
        end
    end

    assign value1 = value1_q;
    assign value2 = value2_q;
    assign page   = page_q;
    assign busy   = busy_q;
    assign upd    = upd_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed scenarios against an event-time reference
// model of the page scheduler, compared with the DUT on every cycle.
`timescale 1ns/1ps
module tb_display_scheduler;
    localparam int DWELL = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] ch_data [4];
    logic [3:0]  ch_valid;
    logic        hold;
    logic        next_page;
    logic [15:0] value1;
    logic [15:0] value2;
    logic        page;
    logic        busy;
    logic        upd;

    always #5 clk = ~clk;

    display_scheduler #(.DWELL_CYCLES(DWELL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_data0  (ch_data[0]),
        .ch_data1  (ch_data[1]),
        .ch_data2  (ch_data[2]),
        .ch_data3  (ch_data[3]),
        .ch_valid  (ch_valid),
        .hold      (hold),
        .next_page (next_page),
        .value1    (value1),
        .value2    (value2),
        .page      (page),
        .busy      (busy),
        .upd       (upd)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit started  = 0;

    // Reference model: conversion result = decimal digits of the snapshot,
    // committed a fixed 16 edges after the trigger edge.
    int          m_sh [4];
    logic [15:0] m_v1, m_v2;
    bit          m_page, m_upd, m_busy, m_pend, m_tgt;
    int          m_cnt, m_snap_at, m_commit_at, m_a, m_b;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 60)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                         nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        started = 1;
        m_upd = 0;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_sh[i] = 0;
            m_v1 = '0; m_v2 = '0;
            m_page = 0; m_busy = 0; m_pend = 0; m_tgt = 0;
            m_cnt = 0; m_snap_at = -1; m_commit_at = -1;
            m_a = 0; m_b = 0;
        end else begin
            if (m_busy) begin
                if (next_page) m_pend = 1;
                if (cyc == m_snap_at) begin
                    m_a = m_sh[2 * m_tgt];
                    m_b = m_sh[2 * m_tgt + 1];
                end
                if (cyc == m_commit_at) begin
                    m_v1 = to_bcd(m_a);
                    m_v2 = to_bcd(m_b);
                    m_page = m_tgt;
                    m_upd = 1;
                    m_busy = 0;
                end
            end else if (next_page || m_pend || m_cnt == DWELL - 1) begin
                m_tgt = (next_page || m_pend || !hold) ? !m_page : m_page;
                m_cnt = 0;
                m_pend = 0;
                m_busy = 1;
                m_snap_at = cyc + 1;
                m_commit_at = cyc + 16;
            end else begin
                m_cnt++;
            end
            for (int i = 0; i < 4; i++)
                if (ch_valid[i]) m_sh[i] = sat(int'(ch_data[i]));
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_value1", value1, m_v1);
            chk("cyc_value2", value2, m_v2);
            chk("cyc_page", page, m_page);
            chk("cyc_busy", busy, m_busy);
            chk("cyc_upd", upd, m_upd);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_np();
        next_page = 1'b1;
        tick(1);
        next_page = 1'b0;
    endtask

    task automatic wait_upd(input string nm, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (upd === 1'b1) begin
                at = cyc;
                break;
            end
        end
        n_checks++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL %s: no upd within %0d cycles", nm, budget);
        end
    endtask

    task automatic count_upd(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (upd === 1'b1) cnt++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, t1, t2, p, prev, rel, n;
        rst_n = 1'b0; hold = 1'b0; next_page = 1'b0; ch_valid = '0;
        for (int i = 0; i < 4; i++) ch_data[i] = '0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) ch_data[i] = 14'($urandom);
            ch_valid = 4'($urandom);
            hold = 1'($urandom);
            next_page = 1'($urandom);
            tick(1);
        end
        ch_valid = '0; hold = 1'b0; next_page = 1'b0;
        for (int i = 0; i < 4; i++) ch_data[i] = '0;
        rst_n = 1'b1;
        rel = cyc;
        tick(1);
        chk("rst_value1", value1, 16'h0000);
        chk("rst_value2", value2, 16'h0000);
        chk("rst_page", page, 0);
        chk("rst_busy", busy, 0);
        chk("rst_upd", upd, 0);

        // Refresh under hold: page stays 0
        hold = 1'b1;
        ch_data[0] = 14'd1234; ch_data[1] = 14'd567; ch_valid = 4'b0011;
        tick(1);
        ch_valid = '0;
        wait_upd("refresh_upd", 200, t);
        chk("refresh_latency", t - rel, DWELL + 16);
        chk("refresh_value1", value1, 16'h1234);
        chk("refresh_value2", value2, 16'h0567);
        chk("refresh_page", page, 0);
        tick(1);
        chk("refresh_upd_one_cycle", upd, 0);

        // Saturation plus explicit page request
        ch_data[2] = 14'd12000; ch_data[3] = 14'd9999; ch_valid = 4'b1100;
        tick(1);
        ch_valid = '0;
        p = cyc;
        pulse_np();
        wait_upd("sat_upd", 30, t);
        chk("sat_latency", t - p, 17);
        chk("sat_page", page, 1);
        chk("sat_value1", value1, 16'h9999);
        chk("sat_value2", value2, 16'h9999);

        // Free-running rotation
        hold = 1'b0;
        prev = t;
        for (int k = 0; k < 3; k++) begin
            wait_upd("rot_upd", 200, t);
            chk("rot_gap", t - prev, DWELL + 16);
            chk("rot_page", page, (k % 2 == 0) ? 0 : 1);
            chk("rot_value1", value1, (k % 2 == 0) ? 16'h1234 : 16'h9999);
            prev = t;
        end

        // Two requests while busy, plus new ch0 during CONV
        p = cyc;
        pulse_np();
        tick(4);
        ch_data[0] = 14'd8888; ch_valid = 4'b0001; next_page = 1'b1;
        tick(1);
        ch_valid = '0; next_page = 1'b0;
        tick(2);
        pulse_np();
        wait_upd("busy_upd1", 30, t1);
        chk("busy_lat1", t1 - p, 17);
        chk("busy_page1", page, 1);
        chk("busy_value1_a", value1, 16'h9999);
        wait_upd("busy_upd2", 30, t2);
        chk("busy_gap", t2 - t1, 17);
        chk("busy_page2", page, 0);
        chk("busy_value1_b", value1, 16'h8888);
        chk("busy_value2_b", value2, 16'h0567);
        count_upd(90, n);
        chk("busy_no_extra_upd", n, 0);

        // Reset at CONV step 7
        p = cyc;
        pulse_np();
        tick(7);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_value1", value1, 16'h0000);
        chk("midrst_value2", value2, 16'h0000);
        chk("midrst_page", page, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_upd", upd, 0);
        rst_n = 1'b1;
        count_upd(40, n);
        chk("midrst_no_upd", n, 0);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
